// File: rtl/rflp256x12_ctrl.sv
// rflp256x12_ctrl: request/response front end for one 256x12 single-port
// synchronous register-file macro. Every macro pin is driven straight from a
// flop so the macro input setup/hold windows see clean, glitch-free edges.
// After reset the whole array is optionally filled with INIT_VAL before any
// client request is accepted. Only one transaction is in flight at a time.
module rflp256x12_ctrl #(
  parameter int unsigned INIT_EN  = 1,
  parameter logic [11:0] INIT_VAL = 12'h000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [7:0]  req_addr,
  input  logic [11:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [11:0] rsp_rdata,
  output logic        init_done,
  output logic        NCE,
  output logic        NWRT,
  output logic [5:0]  RA,
  output logic [1:0]  CA,
  output logic [11:0] DIN,
  input  logic [11:0] DO
);

  localparam int DATA_W = 12;
  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_WR      = 3'd2,
    S_RD_CMD  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  localparam state_t RST_STATE = (INIT_EN != 0) ? S_INIT : S_IDLE;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;         // next fill address
  logic                wrap_q, wrap_d;       // fill counter has wrapped 255 -> 0
  logic                nce_q, nce_d;
  logic                nwrt_q, nwrt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;       // {RA, CA}
  logic [DATA_W-1:0]   din_q, din_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                init_done_q, init_done_d;

  // Next-state and next-pin decode; pin values are computed for the state
  // being entered so that they appear on the macro for that whole cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wrap_d      = wrap_q;
    nce_d       = nce_q;
    nwrt_d      = nwrt_q;
    addr_d      = addr_q;
    din_d       = din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    init_done_d = init_done_q;
    case (state_q)
      S_INIT: begin
        if (!wrap_q) begin
          // One fill write per cycle; the last address is driven on the
          // edge where the counter wraps back to zero.
          nce_d  = 1'b0;
          nwrt_d = 1'b0;
          addr_d = cnt_q;
          din_d  = INIT_VAL;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'hFF) wrap_d = 1'b1;
        end else begin
          nce_d       = 1'b1;
          nwrt_d      = 1'b1;
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_IDLE: begin
        // Also covers INIT_EN=0, where init_done rises one cycle after reset.
        init_done_d = 1'b1;
        nce_d       = 1'b1;
        nwrt_d      = 1'b1;
        if (req_valid) begin
          nce_d  = 1'b0;
          addr_d = req_addr;
          if (req_wr) begin
            nwrt_d  = 1'b0;
            din_d   = req_wdata;
            state_d = S_WR;
          end else begin
            state_d = S_RD_CMD;
          end
        end
      end
      S_WR: begin
        nce_d   = 1'b1;
        nwrt_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_RD_CMD: begin
        // Macro latches the read at this edge; DO settles during RD_WAIT.
        nce_d   = 1'b1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        rsp_rdata_d = DO;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase
  end

  // State, fill counter, macro pins and response registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      wrap_q      <= 1'b0;
      nce_q       <= 1'b1;
      nwrt_q      <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_d;
      nce_q       <= nce_d;
      nwrt_q      <= nwrt_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;
  assign NCE       = nce_q;
  assign NWRT      = nwrt_q;
  assign RA        = addr_q[7:2];
  assign CA        = addr_q[1:0];
  assign DIN       = din_q;

endmodule

// File: tb/tb_rflp256x12_ctrl.sv
// Bench for rflp256x12_ctrl with a behavioural 256x12 synchronous macro model.
// Read expectations go into a queue when a read is accepted and are compared
// when the response handshake happens.
module tb_rflp256x12_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [11:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [11:0] rsp_rdata;
  logic        init_done;
  logic        NCE, NWRT;
  logic [5:0]  RA;
  logic [1:0]  CA;
  logic [11:0] DIN;
  logic [11:0] DO = '0;

  rflp256x12_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .NCE(NCE), .NWRT(NWRT), .RA(RA), .CA(CA), .DIN(DIN), .DO(DO)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [11:0] sb[$];

  // Macro model, pre-loaded with non-zero garbage so the fill is visible.
  logic [11:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 12'hA5A ^ 12'(i);

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!NCE) begin
      if (!NWRT) mem[{RA, CA}] <= DIN;
      else       DO <= mem[{RA, CA}];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Response scoreboard: a handshake at the coming posedge pops one entry.
  always @(negedge CLK) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got %h expected no response", rsp_rdata);
      end else begin
        chk("rsp_data", {20'd0, rsp_rdata}, {20'd0, sb.pop_front()});
      end
    end
  end

  task automatic do_reset(input int n);
    RST = 1'b1;
    req_valid = 1'b0;
    repeat (n) tick();
    chk("reset_vals", {NCE, NWRT, RA, CA, DIN, req_ready, rsp_valid, rsp_rdata, init_done},
        {1'b1, 1'b1, 6'h00, 2'b00, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0});
    RST = 1'b0;
  endtask

  task automatic check_fill();
    int bad = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      if ({NCE, NWRT, RA, CA, DIN, req_ready, init_done} !==
          {1'b0, 1'b0, 8'(k), 12'h000, 1'b0, 1'b0}) begin
        bad++;
        if (bad < 4)
          chk("fill_pins", {8'd0, NCE, NWRT, RA, CA, DIN, req_ready, init_done},
              {8'd0, 1'b0, 1'b0, 8'(k), 12'h000, 1'b0, 1'b0});
      end
    end
    chk("fill_bad_cycles", bad, 0);
    tick();
    chk("fill_end", {NCE, NWRT, req_ready, init_done}, 4'b1111);
  endtask

  // Present a request, wait (bounded) for acceptance, return the accept cycle.
  task automatic accept(input logic wr, input logic [7:0] addr, input logic [11:0] wdata,
                        input logic [11:0] exp, input bit hold, output int acc_cyc);
    int t = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    while (req_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (req_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready=%b expected 1", req_ready);
    end
    tick();
    acc_cyc = cyc;
    if (!wr) sb.push_back(exp);
    if (!hold) req_valid = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [11:0] wdata;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int acc, prev_acc, t, e1;
    logic [11:0] held;
    tbl[0]  = '{1'b0, 8'hA7, 12'h000, 12'h000};
    tbl[1]  = '{1'b1, 8'h00, 12'h111, 12'h000};
    tbl[2]  = '{1'b1, 8'hFF, 12'hFFF, 12'h000};
    tbl[3]  = '{1'b1, 8'h80, 12'h800, 12'h000};
    tbl[4]  = '{1'b0, 8'h00, 12'h000, 12'h111};
    tbl[5]  = '{1'b0, 8'hFF, 12'h000, 12'hFFF};
    tbl[6]  = '{1'b0, 8'h80, 12'h000, 12'h800};
    tbl[7]  = '{1'b0, 8'h01, 12'h000, 12'h000};
    tbl[8]  = '{1'b1, 8'h01, 12'h5A5, 12'h000};
    tbl[9]  = '{1'b0, 8'h01, 12'h000, 12'h5A5};
    tbl[10] = '{1'b0, 8'h7F, 12'h000, 12'h000};

    // Reset and zero-fill.
    do_reset(3);
    check_fill();

    // Table: back-to-back writes keep req_valid high; reads use rsp_ready=1.
    rsp_ready = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 11; i++) begin
      bit hold;
      hold = tbl[i].wr && (i + 1 < 11) && tbl[i + 1].wr;
      accept(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp, hold, acc);
      if (i > 0 && tbl[i].wr && tbl[i - 1].wr) chk("b2b_write_spacing", acc - prev_acc, 2);
      prev_acc = acc;
    end
    t = 0;
    while (sb.size() != 0 && t < 20) begin tick(); t++; end
    chk("table_drained", sb.size(), 0);

    // Write then read 8'h3C: pin timing and 2-cycle latency.
    accept(1'b1, 8'h3C, 12'hABC, 12'h000, 1'b0, acc);
    chk("wr_pins", {NCE, NWRT, RA, CA, DIN}, {1'b0, 1'b0, 6'h0F, 2'b00, 12'hABC});
    accept(1'b0, 8'h3C, 12'h000, 12'hABC, 1'b0, acc);
    chk("rd_cmd_pins", {NCE, NWRT, RA, CA, rsp_valid}, {1'b0, 1'b1, 6'h0F, 2'b00, 1'b0});
    tick();
    chk("rd_wait", {NCE, rsp_valid}, 2'b10);
    tick();
    chk("rsp_latency", {rsp_valid, cyc - acc}, {1'b1, 32'd2});
    tick();
    chk("rsp_done", {rsp_valid, req_ready}, 2'b01);

    // Stalled response: held stable for 5 cycles.
    rsp_ready = 1'b0;
    accept(1'b0, 8'h3C, 12'h000, 12'hABC, 1'b0, acc);
    tick();
    tick();
    held = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {rsp_valid, rsp_rdata, req_ready, NCE}, {1'b1, 12'hABC, 1'b0, 1'b1});
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("stall_taken", {rsp_valid, rsp_rdata, req_ready}, {1'b0, held, 1'b1});
    chk("stall_drained", sb.size(), 0);

    // Reset during RD_WAIT discards the response and refills.
    rsp_ready = 1'b0;
    accept(1'b0, 8'h3C, 12'h000, 12'hABC, 1'b0, acc);
    tick();
    e1 = cyc;
    chk("abort_rd_wait", {NCE, rsp_valid, cyc - acc}, {1'b1, 1'b0, 32'd1});
    RST = 1'b1;
    tick();
    sb.delete();
    chk("abort_reset_vals", {NCE, NWRT, RA, CA, DIN, req_ready, rsp_valid, rsp_rdata, init_done},
        {1'b1, 1'b1, 6'h00, 2'b00, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0});
    rsp_ready = 1'b1;
    do_reset(2);
    check_fill();
    accept(1'b0, 8'h3C, 12'h000, 12'h000, 1'b0, acc);
    t = 0;
    while (sb.size() != 0 && t < 20) begin tick(); t++; end
    chk("final_drained", sb.size(), 0);
    if (e1 < 0) chk("unused", e1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
